// File: rtl/counter_b4_sequencer.sv
// counter_b4_sequencer: round-robin job controller that shares one 4-bit up/down/load counter between two requesters.
// Ports:
//   sq_clk, sq_reset_L            clock, synchronous active-low reset
//   sq_req / sq_gnt / sq_done     per-requester request level, one-hot grant, one-cycle done pulse
//   sq_mode*/sq_D*/sq_steps*      per-requester job description (mode, start value, run cycles)
//   sq_result, sq_wraps           final Q and saturating rco count of the last job
//   sq_busy, sq_err               not idle; sticky missing-load-acknowledge flag
//   cnt_enable/cnt_mode/cnt_D     drive to the shared counter
//   cnt_Q/cnt_rco/cnt_load        registered status back from the counter
module counter_b4_sequencer #(
  parameter int STEPS_W = 4
) (
  input  logic               sq_clk,
  input  logic               sq_reset_L,
  input  logic [1:0]         sq_req,
  input  logic [1:0]         sq_mode0,
  input  logic [1:0]         sq_mode1,
  input  logic [3:0]         sq_D0,
  input  logic [3:0]         sq_D1,
  input  logic [STEPS_W-1:0] sq_steps0,
  input  logic [STEPS_W-1:0] sq_steps1,
  output logic [1:0]         sq_gnt,
  output logic [1:0]         sq_done,
  output logic [3:0]         sq_result,
  output logic [3:0]         sq_wraps,
  output logic               sq_busy,
  output logic               sq_err,
  output logic               cnt_enable,
  output logic [1:0]         cnt_mode,
  output logic [3:0]         cnt_D,
  input  logic [3:0]         cnt_Q,
  input  logic               cnt_rco,
  input  logic               cnt_load
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic ptr, ptr_n, sel, chk, err_n, cnt_enable_n;
  logic [1:0] mode_l, mode_s, gnt_n, done_n, cnt_mode_n;
  logic [3:0] d_l, d_s, wraps_n, result_n, cnt_D_n;
  logic [STEPS_W-1:0] steps_l, steps_s, rem, rem_n;
  // Pointer's requester wins if it is asking, otherwise the other one.
  assign sel = sq_req[ptr] ? ptr : ~ptr;
  // Job description: live inputs during the IDLE grant cycle, latched copy afterwards.
  assign mode_s = state == IDLE ? (sel ? sq_mode1 : sq_mode0) : mode_l;
  assign d_s = state == IDLE ? (sel ? sq_D1 : sq_D0) : d_l;
  assign steps_s = state == IDLE ? (sel ? sq_steps1 : sq_steps0) : steps_l;
  always_comb begin
    state_n = state;
    rem_n = rem;
    unique case (state)
      IDLE: state_n = |sq_req ? LOAD : IDLE;
      LOAD: begin
        state_n = (mode_l == 2'b11 || steps_l == '0) ? DRAIN : RUN;
        rem_n = steps_l;
      end
      RUN: begin
        state_n = rem == STEPS_W'(1) ? DRAIN : RUN;
        rem_n = rem - STEPS_W'(1);
      end
      DRAIN: state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Outputs are registered, so they are derived from the state being entered.
    cnt_enable_n = state_n == LOAD || state_n == RUN;
    cnt_mode_n = state_n == LOAD ? 2'b11 : state_n == RUN ? mode_s : 2'b00;
    cnt_D_n = state_n == LOAD ? d_s : 4'd0;
    gnt_n = state_n == IDLE ? 2'b00 : state == IDLE ? (sel ? 2'b10 : 2'b01) : sq_gnt;
    done_n = state_n == DONE ? sq_gnt : 2'b00;
    result_n = state == DRAIN ? cnt_Q : sq_result;
    // rco lags the counter by one cycle, so DRAIN and DONE still collect the last run step's carry.
    wraps_n = (state == IDLE && |sq_req) ? 4'd0 :
              (cnt_rco && (state == RUN || state == DRAIN || state == DONE) && sq_wraps != 4'hf) ? sq_wraps + 4'd1 :
              sq_wraps;
    err_n = sq_err | (chk & ~cnt_load);
    ptr_n = state == DONE ? ~sq_gnt[1] : ptr;
  end
  always_ff @(posedge sq_clk) begin
    if (!sq_reset_L) begin
      state <= IDLE;
      ptr <= 1'b0;
      chk <= 1'b0;
      mode_l <= 2'b00;
      d_l <= 4'd0;
      steps_l <= '0;
      rem <= '0;
      sq_gnt <= 2'b00;
      sq_done <= 2'b00;
      sq_result <= 4'd0;
      sq_wraps <= 4'd0;
      sq_busy <= 1'b0;
      sq_err <= 1'b0;
      cnt_enable <= 1'b0;
      cnt_mode <= 2'b00;
      cnt_D <= 4'd0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      chk <= state == LOAD;
      mode_l <= mode_s;
      d_l <= d_s;
      steps_l <= steps_s;
      rem <= rem_n;
      sq_gnt <= gnt_n;
      sq_done <= done_n;
      sq_result <= result_n;
      sq_wraps <= wraps_n;
      sq_busy <= state_n != IDLE;
      sq_err <= err_n;
      cnt_enable <= cnt_enable_n;
      cnt_mode <= cnt_mode_n;
      cnt_D <= cnt_D_n;
    end
  end
endmodule

// File: tb/tb_counter_b4_sequencer.sv
// tb_counter_b4_sequencer: scoreboard bench for counter_b4_sequencer with a behavioural 4-bit counter attached.
module tb_counter_b4_sequencer;
  localparam int SW = 4;
  logic sq_clk = 1'b0, sq_reset_L = 1'b0;
  logic [1:0] sq_req = 2'b00, sq_mode0 = 2'b00, sq_mode1 = 2'b00;
  logic [3:0] sq_D0 = 4'd0, sq_D1 = 4'd0;
  logic [SW-1:0] sq_steps0 = '0, sq_steps1 = '0;
  logic [1:0] sq_gnt, sq_done, cnt_mode;
  logic [3:0] sq_result, sq_wraps, cnt_D;
  logic sq_busy, sq_err, cnt_enable, cnt_load;
  logic [3:0] cnt_Q = 4'd0;
  logic cnt_rco = 1'b0, load_r = 1'b0, kill = 1'b0;
  int checks = 0, fails = 0;
  typedef struct {int idx; int r; int w; int len; int err;} exp_t;
  exp_t sb[$];
  int ptr_m = 0, err_m = 0, glen = 0;
  int md[2], dd[2], sd[2];

  counter_b4_sequencer #(.STEPS_W(SW)) dut (
    .sq_clk(sq_clk), .sq_reset_L(sq_reset_L), .sq_req(sq_req),
    .sq_mode0(sq_mode0), .sq_mode1(sq_mode1), .sq_D0(sq_D0), .sq_D1(sq_D1),
    .sq_steps0(sq_steps0), .sq_steps1(sq_steps1),
    .sq_gnt(sq_gnt), .sq_done(sq_done), .sq_result(sq_result), .sq_wraps(sq_wraps),
    .sq_busy(sq_busy), .sq_err(sq_err), .cnt_enable(cnt_enable), .cnt_mode(cnt_mode),
    .cnt_D(cnt_D), .cnt_Q(cnt_Q), .cnt_rco(cnt_rco), .cnt_load(cnt_load)
  );

  always #5 sq_clk = ~sq_clk;

  // Shared counter: registered Q, rco on wrap, load flag; kill forces the load acknowledge low.
  assign cnt_load = kill ? 1'b0 : load_r;
  always @(posedge sq_clk) begin
    load_r <= cnt_enable && cnt_mode == 2'b11;
    cnt_rco <= 1'b0;
    if (cnt_enable)
      case (cnt_mode)
        2'b00: begin cnt_Q <= cnt_Q + 4'd3; cnt_rco <= cnt_Q > 4'd12; end
        2'b01: begin cnt_Q <= cnt_Q - 4'd1; cnt_rco <= cnt_Q == 4'd0; end
        2'b10: begin cnt_Q <= cnt_Q + 4'd1; cnt_rco <= cnt_Q == 4'd15; end
        default: cnt_Q <= cnt_D;
      endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk the job step by step in plain integers.
  function automatic void ref_job(input int m, input int d, input int s, output exp_t e);
    int v, delta, n;
    v = d;
    delta = m == 0 ? 3 : m == 1 ? -1 : 1;
    n = m == 3 ? 0 : s;
    e.w = 0;
    for (int i = 0; i < n; i++) begin
      v += delta;
      if (v > 15 || v < 0) begin
        v = (v + 16) % 16;
        if (e.w < 15) e.w++;
      end
    end
    e.r = v;
    e.len = n == 0 ? 3 : n + 3;
  endfunction

  task automatic set_in(input int i, input int m, input int d, input int s);
    md[i] = m; dd[i] = d; sd[i] = s;
    if (i == 0) begin sq_mode0 = 2'(m); sq_D0 = 4'(d); sq_steps0 = SW'(s); end
    else begin sq_mode1 = 2'(m); sq_D1 = 4'(d); sq_steps1 = SW'(s); end
  endtask

  task automatic scramble();
    set_in(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    set_in(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after the job's DONE.
  task automatic job(input logic [1:0] req, input bit drop);
    exp_t e;
    int idx, n;
    idx = req[ptr_m] ? ptr_m : 1 - ptr_m;
    ref_job(md[idx], dd[idx], sd[idx], e);
    e.idx = idx;
    e.err = (err_m != 0 || kill) ? 1 : 0;
    err_m = e.err;
    sb.push_back(e);
    ptr_m = 1 - idx;
    sq_req = req;
    n = 0;
    do begin @(posedge sq_clk); #1; n++; end while (sq_gnt == 2'b00 && n < 4);
    chk("grant", int'(sq_gnt), 1 << idx);
    if (drop) begin
      sq_req = 2'b00;
      scramble();
    end
    n = 0;
    while (sq_done == 2'b00 && n < 30) begin @(posedge sq_clk); #1; n++; end
    if (sq_done == 2'b00) chk("done_timeout", 0, 1);
    @(posedge sq_clk); #1;
    chk("idle_after_done", int'(sq_busy), 0);
    chk("gnt_after_done", int'(sq_gnt), 0);
  endtask

  initial forever begin
    @(negedge sq_clk);
    glen = sq_gnt != 2'b00 ? glen + 1 : 0;
    if (sq_done != 2'b00) begin
      exp_t e;
      if (sb.size() == 0) chk("unexpected_done", int'(sq_done), 0);
      else begin
        e = sb.pop_front();
        chk("done_idx", int'(sq_done), 1 << e.idx);
        chk("gnt_at_done", int'(sq_gnt), 1 << e.idx);
        chk("result", int'(sq_result), e.r);
        chk("wraps", int'(sq_wraps), e.w);
        chk("job_len", glen, e.len);
        chk("err", int'(sq_err), e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge sq_clk);
    #1;
    chk("rst_gnt", int'(sq_gnt), 0);
    chk("rst_done", int'(sq_done), 0);
    chk("rst_busy", int'(sq_busy), 0);
    chk("rst_err", int'(sq_err), 0);
    chk("rst_result", int'(sq_result), 0);
    chk("rst_wraps", int'(sq_wraps), 0);
    chk("rst_enable", int'(cnt_enable), 0);
    chk("rst_mode", int'(cnt_mode), 0);
    chk("rst_D", int'(cnt_D), 0);
    sq_reset_L = 1'b1;
    @(posedge sq_clk); #1;
    set_in(0, 2, 3, 5);
    job(2'b01, 1'b1);
    set_in(1, 0, 12, 2);
    job(2'b10, 1'b1);
    set_in(0, 2, 7, 1);
    set_in(1, 2, 14, 1);
    for (int k = 0; k < 4; k++) job(2'b11, 1'b0);
    sq_req = 2'b00;
    set_in(0, 3, 9, 7);
    job(2'b01, 1'b1);
    set_in(0, 3, 4, 0);
    kill = 1'b1;
    job(2'b01, 1'b1);
    kill = 1'b0;
    set_in(0, 1, 5, 0);
    job(2'b01, 1'b1);
    chk("err_sticky", int'(sq_err), 1);
    set_in(0, 2, 0, 10);
    sq_req = 2'b01;
    @(posedge sq_clk); #1;
    chk("gnt_before_abort", int'(sq_gnt), 1);
    sq_req = 2'b00;
    repeat (3) @(posedge sq_clk);
    #1;
    chk("busy_in_run", int'(sq_busy), 1);
    chk("enable_in_run", int'(cnt_enable), 1);
    sq_reset_L = 1'b0;
    @(posedge sq_clk); #1;
    chk("abort_gnt", int'(sq_gnt), 0);
    chk("abort_enable", int'(cnt_enable), 0);
    chk("abort_busy", int'(sq_busy), 0);
    chk("abort_done", int'(sq_done), 0);
    chk("abort_err", int'(sq_err), 0);
    sq_reset_L = 1'b1;
    ptr_m = 0;
    err_m = 0;
    repeat (2) @(posedge sq_clk);
    #1;
    set_in(0, 0, 1, 4);
    set_in(1, 1, 2, 3);
    job(2'b11, 1'b1);
    for (int k = 0; k < 30; k++) begin
      scramble();
      job(2'(int'($urandom_range(1, 3))), 1'($urandom_range(0, 1)));
    end
    sq_req = 2'b00;
    repeat (3) @(posedge sq_clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
